ccip_c1_wr_throttle: RTL and testbench

Buffers and meters CCI-P channel-1 (write) requests between the NLB AFU Tx port and the PR-side interface register stage. Holds a small FIFO, honours the platform's c1 almost-full, limits outstanding writes awaiting responses, and drains all outstanding writes before releasing a write fence. Gives the AFU its own almost-full so it never writes into a full buffer.

---
 rtl/ccip_c1_wr_throttle_if.sv | 29 ++
 rtl/ccip_c1_wr_throttle.sv | 158 +++++++++++++++
 tb/tb_ccip_c1_wr_throttle.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ccip_c1_wr_throttle_if.sv
// rtl/ccip_c1_wr_throttle_if.sv - CCI-P c1 write path bundle: AFU side, tx side, platform almost-full and write responses
interface ccip_c1_wr_throttle_if #(
  parameter int HDR_W  = 80,
  parameter int DATA_W = 512
);
  logic              afu_c1_valid;
  logic [HDR_W-1:0]  afu_c1_hdr;
  logic [DATA_W-1:0] afu_c1_data;
  logic              afu_almFull;
  logic              tx_c1_valid;
  logic [HDR_W-1:0]  tx_c1_hdr;
  logic [DATA_W-1:0] tx_c1_data;
  logic              plat_c1TxAlmFull;
  logic              rx_c1_rspValid;
  logic              rx_c1_rspIsFence;
  logic [1:0]        rx_c1_rspClCnt;

  modport slave (
    input  afu_c1_valid, afu_c1_hdr, afu_c1_data,
    input  plat_c1TxAlmFull, rx_c1_rspValid, rx_c1_rspIsFence, rx_c1_rspClCnt,
    output afu_almFull, tx_c1_valid, tx_c1_hdr, tx_c1_data
  );

  modport master (
    output afu_c1_valid, afu_c1_hdr, afu_c1_data,
    output plat_c1TxAlmFull, rx_c1_rspValid, rx_c1_rspIsFence, rx_c1_rspClCnt,
    input  afu_almFull, tx_c1_valid, tx_c1_hdr, tx_c1_data
  );
endinterface

// File: rtl/ccip_c1_wr_throttle.sv
// rtl/ccip_c1_wr_throttle.sv - c1 write FIFO with platform almost-full, outstanding-write cap and fence drain
// Optional CCIP_C1_WR_THROTTLE_STATS_EN adds stall-cycle and fence counters.
module ccip_c1_wr_throttle #(
  parameter int DEPTH           = 8,
  parameter int ALMFULL_MARGIN  = 3,
  parameter int MAX_OUTSTANDING = 64,
  parameter int HDR_W           = 80,
  parameter int DATA_W          = 512
) (
  input  logic                        pClk,
  input  logic                        pck_cp2af_softReset_n,
  ccip_c1_wr_throttle_if.slave        c1,
  output logic [7:0]                  outstanding,
  output logic                        err_overflow
`ifdef CCIP_C1_WR_THROTTLE_STATS_EN
  ,
  output logic [31:0]                 stat_stall_cycles,
  output logic [15:0]                 stat_fence_cnt
`endif
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    ALM_FILL   = (AW+1)'(DEPTH - ALMFULL_MARGIN);
  localparam logic [7:0]     MAX_OUT    = 8'(MAX_OUTSTANDING);
  localparam int             OUT_THR    = MAX_OUTSTANDING - DEPTH;
  localparam logic [7:0]     OUT_THR_V  = (OUT_THR > 0) ? 8'(OUT_THR) : 8'd0;
  localparam logic [3:0]     REQ_FENCE  = 4'h4;

  typedef enum logic {RUN, FENCE_WAIT} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        outstanding_q, outstanding_d;
  logic              err_overflow_q, err_overflow_d;
  logic              almfull_q, almfull_d;
  logic              tx_valid_q, tx_valid_d;
  logic [HDR_W-1:0]  tx_hdr_q, tx_hdr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic [HDR_W-1:0]  hdr_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic              empty, full, head_fence, issue, push;
  logic [HDR_W-1:0]  head_hdr;
  logic [DATA_W-1:0] head_data;
  logic [AW:0]       fill_d;
  logic [8:0]        out_sum, out_dec;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_hdr   = hdr_mem_q[rd_ptr_q[AW-1:0]];
  assign head_data  = data_mem_q[rd_ptr_q[AW-1:0]];
  assign head_fence = (head_hdr[3:0] == REQ_FENCE);

  // A fence leaves the head only once every earlier write has been acknowledged.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      RUN: begin
        if (!empty) begin
          if (head_fence) begin
            state_d = FENCE_WAIT;
          end else if (!c1.plat_c1TxAlmFull && (outstanding_q < MAX_OUT)) begin
            issue = 1'b1;
          end
        end
      end
      FENCE_WAIT: begin
        if (!empty && (outstanding_q == 8'd0) && !c1.plat_c1TxAlmFull) begin
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A pop in the same cycle makes room, so a push into a full FIFO is still accepted.
  always_comb begin
    push           = c1.afu_c1_valid && (!full || issue);
    err_overflow_d = err_overflow_q || (c1.afu_c1_valid && full && !issue);
    wr_ptr_d       = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d       = rd_ptr_q + (AW+1)'(issue);
    fill_d         = wr_ptr_d - rd_ptr_d;

    out_sum = {1'b0, outstanding_q} + 9'(issue && !head_fence);
    out_dec = (c1.rx_c1_rspValid && !c1.rx_c1_rspIsFence) ? (9'(c1.rx_c1_rspClCnt) + 9'd1) : 9'd0;
    outstanding_d = (out_dec > out_sum) ? 8'd0 : 8'(out_sum - out_dec);

    almfull_d  = (fill_d >= ALM_FILL) || (outstanding_d >= OUT_THR_V);
    tx_valid_d = issue;
    tx_hdr_d   = issue ? head_hdr  : tx_hdr_q;
    tx_data_d  = issue ? head_data : tx_data_q;
  end

  always_ff @(posedge pClk) begin
    if (push) begin
      hdr_mem_q[wr_ptr_q[AW-1:0]]  <= c1.afu_c1_hdr;
      data_mem_q[wr_ptr_q[AW-1:0]] <= c1.afu_c1_data;
    end
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      outstanding_q  <= '0;
      err_overflow_q <= 1'b0;
      almfull_q      <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_hdr_q       <= '0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      outstanding_q  <= outstanding_d;
      err_overflow_q <= err_overflow_d;
      almfull_q      <= almfull_d;
      tx_valid_q     <= tx_valid_d;
      tx_hdr_q       <= tx_hdr_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign c1.afu_almFull = almfull_q;
  assign c1.tx_c1_valid = tx_valid_q;
  assign c1.tx_c1_hdr   = tx_hdr_q;
  assign c1.tx_c1_data  = tx_data_q;
  assign outstanding    = outstanding_q;
  assign err_overflow   = err_overflow_q;

`ifdef CCIP_C1_WR_THROTTLE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fence_cnt_q, fence_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(!empty && !issue);
    fence_cnt_d = fence_cnt_q + 16'(issue && head_fence);
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      stall_cnt_q <= '0;
      fence_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fence_cnt_q <= fence_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_fence_cnt    = fence_cnt_q;
`endif

endmodule

// File: tb/tb_ccip_c1_wr_throttle.sv
// tb/tb_ccip_c1_wr_throttle.sv - scoreboard bench for ccip_c1_wr_throttle (default cap and a cap-of-4 instance)
module tb_ccip_c1_wr_throttle;
  localparam int HW = 80;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccip_c1_wr_throttle_if #(.HDR_W(HW), .DATA_W(DW)) ifa ();
  ccip_c1_wr_throttle_if #(.HDR_W(HW), .DATA_W(DW)) ifb ();

  logic [7:0] out_a, out_b;
  logic       err_a, err_b;
`ifdef CCIP_C1_WR_THROTTLE_STATS_EN
  logic [31:0] stall_a, stall_b;
  logic [15:0] fcnt_a, fcnt_b;
`endif

  ccip_c1_wr_throttle #(.DEPTH(8), .ALMFULL_MARGIN(3), .MAX_OUTSTANDING(64), .HDR_W(HW), .DATA_W(DW)) dut_a (
    .pClk(clk), .pck_cp2af_softReset_n(rst_n), .c1(ifa), .outstanding(out_a), .err_overflow(err_a)
`ifdef CCIP_C1_WR_THROTTLE_STATS_EN
    , .stat_stall_cycles(stall_a), .stat_fence_cnt(fcnt_a)
`endif
  );

  ccip_c1_wr_throttle #(.DEPTH(8), .ALMFULL_MARGIN(3), .MAX_OUTSTANDING(4), .HDR_W(HW), .DATA_W(DW)) dut_b (
    .pClk(clk), .pck_cp2af_softReset_n(rst_n), .c1(ifb), .outstanding(out_b), .err_overflow(err_b)
`ifdef CCIP_C1_WR_THROTTLE_STATS_EN
    , .stat_stall_cycles(stall_b), .stat_fence_cnt(fcnt_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int iss_a = 0;
  int iss_b = 0;
  int base;
  logic [HW-1:0] exp_hdr_a[$], exp_hdr_b[$];
  logic [DW-1:0] exp_data_a[$], exp_data_b[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int n, input bit fence);
    return {48'(n * 77 + 1), 28'h0, fence ? 4'h4 : 4'h0};
  endfunction

  function automatic logic [DW-1:0] mk_data(input int n);
    return {16{32'(n) ^ 32'h5A5A_0000}};
  endfunction

  task automatic push(input bit b, input int n, input bit fence, input bit track);
    if (!b) begin
      ifa.afu_c1_valid = 1'b1;
      ifa.afu_c1_hdr   = mk_hdr(n, fence);
      ifa.afu_c1_data  = mk_data(n);
      if (track) begin
        exp_hdr_a.push_back(mk_hdr(n, fence));
        exp_data_a.push_back(mk_data(n));
      end
    end else begin
      ifb.afu_c1_valid = 1'b1;
      ifb.afu_c1_hdr   = mk_hdr(n, fence);
      ifb.afu_c1_data  = mk_data(n);
      if (track) begin
        exp_hdr_b.push_back(mk_hdr(n, fence));
        exp_data_b.push_back(mk_data(n));
      end
    end
    @(negedge clk);
    ifa.afu_c1_valid = 1'b0;
    ifb.afu_c1_valid = 1'b0;
  endtask

  task automatic rsp(input bit b, input bit fence, input logic [1:0] cnt);
    if (!b) begin
      ifa.rx_c1_rspValid = 1'b1; ifa.rx_c1_rspIsFence = fence; ifa.rx_c1_rspClCnt = cnt;
    end else begin
      ifb.rx_c1_rspValid = 1'b1; ifb.rx_c1_rspIsFence = fence; ifb.rx_c1_rspClCnt = cnt;
    end
    @(negedge clk);
    ifa.rx_c1_rspValid = 1'b0;
    ifb.rx_c1_rspValid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (ifa.tx_c1_valid === 1'b1) begin
      iss_a++;
      if (exp_hdr_a.size() == 0) check_eq("a_unexpected_issue", 1, 0);
      else begin
        check_eq("a_hdr", ifa.tx_c1_hdr, exp_hdr_a.pop_front());
        check_eq("a_data", ifa.tx_c1_data, exp_data_a.pop_front());
      end
    end
    if (ifb.tx_c1_valid === 1'b1) begin
      iss_b++;
      if (exp_hdr_b.size() == 0) check_eq("b_unexpected_issue", 1, 0);
      else begin
        check_eq("b_hdr", ifb.tx_c1_hdr, exp_hdr_b.pop_front());
        check_eq("b_data", ifb.tx_c1_data, exp_data_b.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.afu_c1_valid = 0; ifa.afu_c1_hdr = '0; ifa.afu_c1_data = '0; ifa.plat_c1TxAlmFull = 0;
    ifa.rx_c1_rspValid = 0; ifa.rx_c1_rspIsFence = 0; ifa.rx_c1_rspClCnt = 0;
    ifb.afu_c1_valid = 0; ifb.afu_c1_hdr = '0; ifb.afu_c1_data = '0; ifb.plat_c1TxAlmFull = 0;
    ifb.rx_c1_rspValid = 0; ifb.rx_c1_rspIsFence = 0; ifb.rx_c1_rspClCnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_tx_valid", ifa.tx_c1_valid, 0);
    check_eq("rst_tx_hdr", ifa.tx_c1_hdr, 0);
    check_eq("rst_almfull", ifa.afu_almFull, 0);
    check_eq("rst_outstanding", out_a, 0);
    check_eq("rst_err", err_a, 0);

    // single write: two-cycle latency, count up then down
    push(0, 1, 0, 1);
    check_eq("single_no_bypass", ifa.tx_c1_valid, 0);
    @(negedge clk);
    check_eq("single_tx_valid", ifa.tx_c1_valid, 1);
    check_eq("single_outstanding", out_a, 1);
    @(negedge clk);
    check_eq("single_hdr_hold", ifa.tx_c1_hdr, mk_hdr(1, 0));
    rsp(0, 0, 2'd0);
    check_eq("single_rsp_outstanding", out_a, 0);

    // fence ordering
    base = iss_a;
    for (int i = 0; i < 3; i++) push(0, 10 + i, 0, 1);
    push(0, 13, 1, 1);
    push(0, 14, 0, 1);
    wait_cyc(8);
    check_eq("fence_pre_issued", iss_a - base, 3);
    check_eq("fence_pre_outstanding", out_a, 3);
    rsp(0, 0, 2'd2);
    wait_cyc(4);
    check_eq("fence_post_issued", iss_a - base, 5);
    check_eq("fence_post_outstanding", out_a, 1);
    rsp(0, 1, 2'd3);
    check_eq("fence_rsp_no_change", out_a, 1);
    rsp(0, 0, 2'd0);
    check_eq("fence_drained", out_a, 0);

    // issue and ClCnt=1 response in the same cycle from outstanding=3
    for (int i = 0; i < 3; i++) push(0, 20 + i, 0, 1);
    wait_cyc(3);
    check_eq("sim_pre_outstanding", out_a, 3);
    push(0, 23, 0, 1);
    ifa.rx_c1_rspValid = 1'b1; ifa.rx_c1_rspIsFence = 1'b0; ifa.rx_c1_rspClCnt = 2'd1;
    @(negedge clk);
    ifa.rx_c1_rspValid = 1'b0;
    check_eq("sim_net_outstanding", out_a, 2);
    rsp(0, 0, 2'd1);
    check_eq("sim_drained", out_a, 0);

    // fill under platform almost-full, push+pop while full, then overflow
    ifa.plat_c1TxAlmFull = 1'b1;
    base = iss_a;
    for (int i = 0; i < 8; i++) begin
      push(0, 30 + i, 0, 1);
      if (i == 3) check_eq("fill_almfull_after_4", ifa.afu_almFull, 0);
      if (i == 4) check_eq("fill_almfull_after_5", ifa.afu_almFull, 1);
    end
    check_eq("fill_no_issue", iss_a - base, 0);
    ifa.plat_c1TxAlmFull = 1'b0;
    push(0, 38, 0, 1);
    ifa.plat_c1TxAlmFull = 1'b1;
    check_eq("full_pushpop_no_overflow", err_a, 0);
    push(0, 39, 0, 0);
    check_eq("overflow_err", err_a, 1);
    wait_cyc(2);
    check_eq("plat_almfull_blocks", iss_a - base, 1);
    ifa.plat_c1TxAlmFull = 1'b0;
    wait_cyc(8);
    check_eq("drain_issued_8_in_8", iss_a - base, 9);
    check_eq("drain_almfull_clear", ifa.afu_almFull, 0);
    check_eq("drain_outstanding", out_a, 9);
    wait_cyc(2);
    check_eq("drain_no_extra", iss_a - base, 9);
    check_eq("overflow_sticky", err_a, 1);
    rsp(0, 0, 2'd3);
    check_eq("packed_rsp", out_a, 5);
    rsp(0, 0, 2'd3);
    rsp(0, 0, 2'd3);
    check_eq("underflow_saturates", out_a, 0);

    // reset with five entries queued behind a fence
    push(0, 40, 0, 1);
    push(0, 41, 1, 0);
    for (int i = 0; i < 4; i++) push(0, 42 + i, 0, 0);
    wait_cyc(2);
    check_eq("midrst_pre_almfull", ifa.afu_almFull, 1);
    check_eq("midrst_pre_outstanding", out_a, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tx_valid", ifa.tx_c1_valid, 0);
    check_eq("midrst_tx_hdr", ifa.tx_c1_hdr, 0);
    check_eq("midrst_almfull", ifa.afu_almFull, 0);
    check_eq("midrst_outstanding", out_a, 0);
    check_eq("midrst_err", err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = iss_a;
    push(0, 50, 0, 1);
    check_eq("post_rst_no_bypass", ifa.tx_c1_valid, 0);
    @(negedge clk);
    check_eq("post_rst_tx_valid", ifa.tx_c1_valid, 1);
    check_eq("post_rst_outstanding", out_a, 1);
    wait_cyc(4);
    check_eq("post_rst_no_stale", iss_a - base, 1);

    // outstanding cap of 4
    base = iss_b;
    for (int i = 0; i < 6; i++) push(1, 60 + i, 0, 1);
    wait_cyc(6);
    check_eq("cap_issued", iss_b - base, 4);
    check_eq("cap_outstanding", out_b, 4);
    rsp(1, 0, 2'd0);
    wait_cyc(3);
    check_eq("cap_release_one", iss_b - base, 5);
    check_eq("cap_outstanding_after", out_b, 4);
    rsp(1, 0, 2'd3);
    wait_cyc(3);
    check_eq("cap_release_last", iss_b - base, 6);
    check_eq("cap_final_outstanding", out_b, 1);

    check_eq("sb_empty_a", exp_hdr_a.size(), 0);
    check_eq("sb_empty_b", exp_hdr_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
